// File: rtl/hex_snapshot_ctrl_pkg.sv
// Shared definitions for the hex snapshot controller and the hex decoder display path.
// Holds the commit state encoding, slot-count derivation and on-screen grid constants.
package hex_snapshot_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } commit_state_t;

    // Grid and colour constants shared with hex_decoder_v
    localparam int unsigned C_GLYPH_W    = 8;
    localparam int unsigned C_GLYPH_H    = 16;
    localparam logic [23:0] C_RGB_FG     = 24'h00FF00;
    localparam logic [23:0] C_RGB_BG     = 24'h000000;

    function automatic int unsigned slots_of(input int unsigned data_len,
                                             input int unsigned word_bits);
        return data_len / word_bits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward with wrap, grants the first requester.
// Produces a one-hot grant plus its binary index; the caller owns the pointer register.
module rr_arbiter #(
    parameter int unsigned c_req      = 4,
    parameter int unsigned c_idx_bits = $clog2(c_req)
) (
    input  logic [c_req-1:0]      req,
    input  logic [c_idx_bits-1:0] ptr,
    output logic [c_req-1:0]      grant,
    output logic [c_idx_bits-1:0] grant_idx
);

    logic                  found_s;
    logic [c_idx_bits:0]   sum_s;
    logic [c_idx_bits-1:0] idx_s;

    // Priority scan starting at ptr; sum is one bit wider so the modulo wrap is exact for any c_req
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        sum_s     = '0;
        idx_s     = '0;
        for (int k = 0; k < c_req; k++) begin
            sum_s = {1'b0, ptr} + (c_idx_bits + 1)'(k);
            if (sum_s >= (c_idx_bits + 1)'(c_req)) begin
                sum_s = sum_s - (c_idx_bits + 1)'(c_req);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[c_idx_bits-1:0];
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_idx    = idx_s;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/hex_snapshot_ctrl.sv
// Debug-word snapshot controller: arbitrated writes into a shadow buffer, committed
// atomically to the display bus on each vsync rising edge unless frozen.
module hex_snapshot_ctrl
    import hex_snapshot_ctrl_pkg::*;
#(
    parameter int unsigned c_data_len   = 1024,
    parameter int unsigned c_word_bits  = 32,
    parameter int unsigned c_slot_bits  = 5,
    parameter int unsigned c_req        = 4,
    parameter int unsigned c_frame_bits = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [c_req-1:0]              req_valid,
    output logic [c_req-1:0]              req_ready,
    input  logic [c_req*c_slot_bits-1:0]  req_slot,
    input  logic [c_req*c_word_bits-1:0]  req_word,
    input  logic                          vsync,
    input  logic                          freeze,
    output logic [c_data_len-1:0]         data,
    output logic                          commit,
    output logic                          dirty,
    output logic [c_frame_bits-1:0]       frame_cnt
);

    localparam int unsigned        c_slots     = slots_of(c_data_len, c_word_bits);
    localparam int unsigned        c_idx_bits  = $clog2(c_req);
    localparam logic [c_slot_bits:0] c_slots_lim = (c_slot_bits + 1)'(c_slots);

    logic [c_req-1:0]        grant_s;
    logic [c_idx_bits-1:0]   grant_idx_s;
    logic [c_idx_bits-1:0]   ptr_r;
    logic [c_slot_bits-1:0]  wr_slot_s;
    logic [c_word_bits-1:0]  wr_word_s;
    logic                    wr_fire_s;
    logic                    wr_hit_s;
    logic                    vsync_d_r;
    logic                    vs_rise_s;
    commit_state_t           state_r;
    logic [c_data_len-1:0]   shadow_r;
    logic [c_data_len-1:0]   data_r;
    logic                    commit_r;
    logic                    dirty_r;
    logic [c_frame_bits-1:0] frame_cnt_r;

    rr_arbiter #(
        .c_req      (c_req),
        .c_idx_bits (c_idx_bits)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign req_ready = grant_s;
    assign wr_fire_s = |grant_s;
    assign wr_slot_s = req_slot[grant_idx_s*c_slot_bits +: c_slot_bits];
    assign wr_word_s = req_word[grant_idx_s*c_word_bits +: c_word_bits];
    // Out-of-range slots complete the handshake but never touch shadow or dirty
    assign wr_hit_s  = wr_fire_s && ({1'b0, wr_slot_s} < c_slots_lim);
    assign vs_rise_s = vsync & ~vsync_d_r;

    // Round-robin pointer advances past the granted requester
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (wr_fire_s) begin
            ptr_r <= (grant_idx_s == c_idx_bits'(c_req - 1)) ? '0 : grant_idx_s + c_idx_bits'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Shadow buffer slot writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_r <= '0;
        end else begin
            for (int s = 0; s < c_slots; s++) begin
                if (wr_hit_s && (wr_slot_s == c_slot_bits'(s))) begin
                    shadow_r[s*c_word_bits +: c_word_bits] <= wr_word_s;
                end else begin
                    shadow_r[s*c_word_bits +: c_word_bits] <= shadow_r[s*c_word_bits +: c_word_bits];
                end
            end
        end
    end

    // Dirty tracking: a write landing in the commit cycle survives the clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dirty_r <= 1'b0;
        end else if (state_r == ST_COMMIT) begin
            dirty_r <= wr_hit_s;
        end else if (wr_hit_s) begin
            dirty_r <= 1'b1;
        end else begin
            dirty_r <= dirty_r;
        end
    end

    // vsync delay starts high so a level already high at reset release is not seen as a rise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_d_r <= 1'b1;
        end else begin
            vsync_d_r <= vsync;
        end
    end

    // Commit FSM with registered display data, commit pulse and frame counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            data_r      <= '0;
            commit_r    <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    commit_r <= 1'b0;
                    if (vs_rise_s && !freeze) begin
                        state_r <= ST_COMMIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    data_r      <= shadow_r;
                    frame_cnt_r <= frame_cnt_r + c_frame_bits'(1);
                    commit_r    <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    commit_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign data      = data_r;
    assign commit    = commit_r;
    assign dirty     = dirty_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_hex_snapshot_ctrl.sv
// Directed self-checking bench for hex_snapshot_ctrl: full-size instance plus a
// 96-bit (3-slot) instance for the out-of-range slot case.
module tb_hex_snapshot_ctrl;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vsync;
    logic          freeze;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [19:0]   req_slot;
    logic [127:0]  req_word;
    logic [1023:0] data;
    logic          commit;
    logic          dirty;
    logic [15:0]   frame_cnt;

    logic [3:0]    s_valid;
    logic [3:0]    s_ready;
    logic [19:0]   s_slot;
    logic [127:0]  s_word;
    logic          s_vsync;
    logic          s_freeze;
    logic [95:0]   s_data;
    logic          s_commit;
    logic          s_dirty;
    logic [15:0]   s_frame;

    int            checks = 0;
    int            errors = 0;
    logic [3:0]    rr_exp [5];

    always #5 clk = ~clk;

    hex_snapshot_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_slot  (req_slot),
        .req_word  (req_word),
        .vsync     (vsync),
        .freeze    (freeze),
        .data      (data),
        .commit    (commit),
        .dirty     (dirty),
        .frame_cnt (frame_cnt)
    );

    hex_snapshot_ctrl #(.c_data_len(96)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (s_valid),
        .req_ready (s_ready),
        .req_slot  (s_slot),
        .req_word  (s_word),
        .vsync     (s_vsync),
        .freeze    (s_freeze),
        .data      (s_data),
        .commit    (s_commit),
        .dirty     (s_dirty),
        .frame_cnt (s_frame)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rr_exp    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n     = 1'b0;
        vsync     = 1'b1;
        freeze    = 1'b0;
        req_valid = 4'b0000;
        req_slot  = 20'h0;
        req_word  = 128'h0;
        s_valid   = 4'b0000;
        s_slot    = 20'h0;
        s_word    = 128'h0;
        s_vsync   = 1'b0;
        s_freeze  = 1'b0;

        // Reset with vsync high, then release with vsync still high
        step(); step();
        chk("rst_data",   128'(|data), 128'd0);
        chk("rst_commit", 128'(commit), 128'd0);
        chk("rst_frame",  128'(frame_cnt), 128'd0);
        chk("rst_dirty",  128'(dirty), 128'd0);
        rst_n = 1'b1;
        step(); step();
        chk("rel_commit", 128'(commit), 128'd0);
        chk("rel_frame",  128'(frame_cnt), 128'd0);
        vsync = 1'b0;
        step();

        // Single write to slot 3 then commit
        req_slot[4:0]  = 5'd3;
        req_word[31:0] = 32'hDEADBEEF;
        req_valid      = 4'b0001;
        #1;
        chk("single_ready", 128'(req_ready), 128'h1);
        step();
        req_valid = 4'b0000;
        chk("single_dirty", 128'(dirty), 128'd1);
        vsync = 1'b1;
        step();
        chk("single_early", 128'(commit), 128'd0);
        step();
        chk("single_commit", 128'(commit), 128'd1);
        chk("single_data",   128'(data[127:96]), 128'hDEADBEEF);
        chk("single_frame",  128'(frame_cnt), 128'd1);
        chk("single_clean",  128'(dirty), 128'd0);
        vsync = 1'b0;
        step();
        chk("single_pulse_end", 128'(commit), 128'd0);

        // Round-robin: req i targets slot 8+i with word A0+i
        for (int i = 0; i < 4; i++) begin
            req_slot[i*5 +: 5]   = 5'(8 + i);
            req_word[i*32 +: 32] = 32'(32'hA0 + i);
        end
        req_valid = 4'b1000;
        #1;
        chk("rr_align", 128'(req_ready), 128'h8);
        step();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr_all_%0d", k), 128'(req_ready), 128'(rr_exp[k]));
            step();
        end
        req_valid = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("rr_only2_%0d", k), 128'(req_ready), 128'h4);
            step();
        end
        req_valid = 4'b0000;
        #1;
        chk("rr_none", 128'(req_ready), 128'h0);
        step();
        req_valid = 4'b0001;
        #1;
        chk("rr_wrap", 128'(req_ready), 128'h1);
        step();
        req_valid = 4'b0000;

        // Write accepted during the COMMIT cycle stays in shadow only
        vsync = 1'b1;
        step();
        req_slot[4:0]  = 5'd0;
        req_word[31:0] = 32'h00000011;
        req_valid      = 4'b0001;
        #1;
        chk("same_ready", 128'(req_ready), 128'h1);
        step();
        req_valid = 4'b0000;
        chk("same_commit", 128'(commit), 128'd1);
        chk("same_slot0",  128'(data[31:0]), 128'h0);
        chk("same_slot8",  128'(data[287:256]), 128'hA0);
        chk("same_slot11", 128'(data[383:352]), 128'hA3);
        chk("same_frame",  128'(frame_cnt), 128'd2);
        chk("same_dirty",  128'(dirty), 128'd1);
        vsync = 1'b0;
        step(); step();
        vsync = 1'b1;
        step(); step();
        chk("same_next_commit", 128'(commit), 128'd1);
        chk("same_next_slot0",  128'(data[31:0]), 128'h11);
        chk("same_next_frame",  128'(frame_cnt), 128'd3);
        chk("same_next_dirty",  128'(dirty), 128'd0);
        vsync = 1'b0;
        step();

        // Freeze suppresses commits; release alone does not commit
        freeze          = 1'b1;
        req_slot[9:5]   = 5'd1;
        req_word[63:32] = 32'h5A5A5A5A;
        req_valid       = 4'b0010;
        #1;
        chk("frz_ready", 128'(req_ready), 128'h2);
        step();
        req_valid = 4'b0000;
        vsync = 1'b1;
        step(); step();
        chk("frz_rise1_commit", 128'(commit), 128'd0);
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step(); step();
        chk("frz_rise2_commit", 128'(commit), 128'd0);
        vsync = 1'b0;
        step();
        chk("frz_frame", 128'(frame_cnt), 128'd3);
        chk("frz_slot1", 128'(data[63:32]), 128'h0);
        chk("frz_dirty", 128'(dirty), 128'd1);
        freeze = 1'b0;
        step(); step();
        chk("unfrz_frame",  128'(frame_cnt), 128'd3);
        chk("unfrz_commit", 128'(commit), 128'd0);
        vsync = 1'b1;
        step(); step();
        chk("unfrz_rise_commit", 128'(commit), 128'd1);
        chk("unfrz_slot1",       128'(data[63:32]), 128'h5A5A5A5A);
        chk("unfrz_frame_inc",   128'(frame_cnt), 128'd4);
        vsync = 1'b0;
        step();

        // Out-of-range slots on the 3-slot instance
        s_slot[4:0]  = 5'd2;
        s_word[31:0] = 32'h22222222;
        s_valid      = 4'b0001;
        #1;
        chk("oor_in_ready", 128'(s_ready), 128'h1);
        step();
        s_valid = 4'b0000;
        chk("oor_in_dirty", 128'(s_dirty), 128'd1);
        s_vsync = 1'b1;
        step(); step();
        chk("oor_in_commit", 128'(s_commit), 128'd1);
        chk("oor_in_data",   128'(s_data), 128'({32'h22222222, 32'h0, 32'h0}));
        chk("oor_in_clean",  128'(s_dirty), 128'd0);
        s_vsync = 1'b0;
        step();
        s_slot[4:0]  = 5'd5;
        s_word[31:0] = 32'hFFFFFFFF;
        s_valid      = 4'b0001;
        #1;
        chk("oor5_ready", 128'(s_ready), 128'h1);
        step();
        s_valid = 4'b0000;
        chk("oor5_dirty", 128'(s_dirty), 128'd0);
        s_slot[4:0] = 5'd3;
        s_valid     = 4'b0001;
        #1;
        chk("oor3_ready", 128'(s_ready), 128'h1);
        step();
        s_valid = 4'b0000;
        chk("oor3_dirty", 128'(s_dirty), 128'd0);
        s_vsync = 1'b1;
        step(); step();
        chk("oor_commit", 128'(s_commit), 128'd1);
        chk("oor_data",   128'(s_data), 128'({32'h22222222, 32'h0, 32'h0}));
        chk("oor_dirty",  128'(s_dirty), 128'd0);
        chk("oor_frame",  128'(s_frame), 128'd2);
        s_vsync = 1'b0;
        step();

        // Reset with a COMMIT pending abandons it
        vsync = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_data",   128'(|data), 128'd0);
        chk("midrst_frame",  128'(frame_cnt), 128'd0);
        chk("midrst_commit", 128'(commit), 128'd0);
        chk("midrst_dirty",  128'(dirty), 128'd0);
        rst_n = 1'b1;
        step(); step();
        chk("midrst_rel_commit", 128'(commit), 128'd0);
        chk("midrst_rel_frame",  128'(frame_cnt), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_snapshot_ctrl.md
Name: hex_snapshot_ctrl

Overview:
- Collects debug words from several requesters (e.g. MIPI lane/packet status counters) into a shadow buffer through a round-robin arbiter.
- Commits the shadow buffer atomically at frame start to the wide data bus that feeds hex_decoder_v. The on-screen hex dump is therefore tear-free and updates once per frame.
- Supports freezing the display for inspection.

Parameters:
- c_data_len, 1024, width of display bus; must equal hex decoder c_data_len and be a multiple of c_word_bits
- c_word_bits, 32, bits per requester word
- c_slot_bits, 5, slot index width; c_slots = c_data_len/c_word_bits must be <= 2^c_slot_bits
- c_req, 4, number of requesters (2..8)
- c_frame_bits, 16, frame counter width

Ports:
- clk  in  1  system clock; only clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  c_req  requester i has a word to write
- req_ready  out  c_req  one-hot grant; transfer when valid&ready
- req_slot  in  c_req*c_slot_bits  slot index of requester i, at bits [i*c_slot_bits +: c_slot_bits]
- req_word  in  c_req*c_word_bits  data of requester i, at bits [i*c_word_bits +: c_word_bits]
- vsync  in  1  frame sync from video timing, level, synchronous to clk
- freeze  in  1  1 = suppress commits, display holds
- data  out  c_data_len  display buffer to hex decoder; slot s occupies [s*c_word_bits +: c_word_bits]
- commit  out  1  one-cycle pulse, high in the cycle the new data first appears
- dirty  out  1  shadow holds writes not yet committed
- frame_cnt  out  c_frame_bits  number of commits, wraps

Behaviour:
- Reset (rst_n=0 at a clk edge): shadow=0, data=0, commit=0, dirty=0, frame_cnt=0, arbiter pointer=0, vsync_d=1. vsync_d=1 prevents a spurious commit if vsync is high at reset release.
- Arbiter:
  - req_ready is combinational from req_valid and the pointer.
  - Scan starts at index ptr, wraps modulo c_req; the first valid requester gets ready=1. At most one ready bit is set.
  - No valid requester: req_ready=0 and ptr unchanged.
  - On grant to index g: ptr <= (g+1) mod c_req at the clock edge.
  - Write is accepted every cycle; there is no backpressure beyond arbitration, including during a commit.
- Write:
  - Accepted word writes shadow[slot] at the clock edge.
  - slot >= c_slots: handshake still completes, data is discarded, dirty unaffected.
  - Valid write sets dirty.
- Edge detect: vsync_d <= vsync every cycle. vs_rise = vsync & ~vsync_d.
- Commit state machine:
  - States: IDLE, COMMIT.
  - IDLE -> COMMIT on vs_rise & ~freeze.
  - In COMMIT, for exactly one cycle: data <= shadow (snapshot taken at the start of the COMMIT cycle), frame_cnt <= frame_cnt+1, then return to IDLE.
  - commit is registered. It is high in the cycle after COMMIT, aligned with the new data.
- Latency: vsync rises at sampled cycle E -> COMMIT at E+1 -> data/commit visible at E+2.
- Write during the COMMIT cycle lands in shadow only, is not part of this snapshot, and leaves dirty=1. Otherwise COMMIT clears dirty.
- freeze=1: vs_rise ignored, data and frame_cnt hold, shadow writes continue. Deasserting freeze does not trigger a commit; the next vs_rise does.
- vs_rise while in COMMIT is impossible, since a rise needs 2 cycles. frame_cnt wraps to 0 past all-ones.
- Reset mid-operation restores all reset values next cycle. A pending COMMIT is abandoned.

Decomposition:
- Shared package: commit state encoding (IDLE/COMMIT), c_slots derivation function, RGB/grid constants already shared with hex_decoder_v.
- One sub-module: rr_arbiter (parameter c_req; ports: req, ptr in, grant one-hot, grant index). Reused by other debug muxes.

Test Plan:
- Reset: rst_n=0 for 2 cycles with vsync=1 -> data=0, commit=0, frame_cnt=0; release with vsync held high -> no commit.
- Single write: req0 slot 3 word 0xDEADBEEF, then vsync 0->1 -> data[127:96]=0xDEADBEEF exactly 2 cycles after vsync sampled high, commit pulses 1 cycle, frame_cnt=1, dirty=0.
- Round-robin: all 4 valid continuously, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; then only req2 valid -> req2 granted every cycle.
- Same-cycle write: write slot 0=0x11 accepted in the COMMIT cycle -> data slot 0 keeps old value, dirty=1; next vsync rise -> slot 0=0x11.
- Freeze: freeze=1, write slot 1=0x5A5A5A5A, two vsync rises -> data unchanged, frame_cnt unchanged; freeze=0 -> no change until next rise, then slot 1 updated and frame_cnt+1.
- Out-of-range: c_data_len=96 (c_slots=3), slot 5 write -> ready asserted, data/dirty unchanged after commit.
